ctrl_encoder: RTL and testbench

Inverse of the opcode control decoder: accepts a decoded control-signal bundle over a valid/ready handshake, re-encodes it into the 4-bit opcode that produces that exact bundle, and streams opcodes out through a 2-entry FIFO. Bundles that match no legal opcode are flagged, counted and dropped. Used by the Generated_Hardware bench and trace path to cross-check the control path against the instruction stream.

---
 rtl/ctrl_encoder.sv | 173 +++++++++++++++++
 tb/tb_ctrl_encoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_encoder.sv
// ctrl_encoder: re-encodes a decoded control bundle into its 4-bit opcode and
// queues opcodes in a 2-entry FIFO. Bundles matching no opcode are dropped and
// flagged. Optional statistics counters are enabled by CTRL_ENC_STATS_EN;
// without it illegal_count and instr_count read 0.
module ctrl_encoder #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          reg_dst,
    input  logic          alu_src,
    input  logic          mem_to_reg,
    input  logic          reg_write,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          beq,
    input  logic          bne,
    input  logic          jump,
    input  logic [1:0]    alu_op,
    input  logic [1:0]    r_sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    opcode,
    output logic          illegal,
    output logic [IW-1:0] illegal_count,
    output logic [15:0]   instr_count
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned BUN_W = 11;

    // Bundle bit order: reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
    // mem_write, beq, bne, jump, alu_op[1:0]
    localparam logic [BUN_W-1:0] ROW_LOAD  = 11'b0_1_1_1_1_0_0_0_0_10;
    localparam logic [BUN_W-1:0] ROW_STORE = 11'b0_1_0_0_0_1_0_0_0_10;
    localparam logic [BUN_W-1:0] ROW_RTYPE = 11'b1_0_0_1_0_0_0_0_0_00;
    localparam logic [BUN_W-1:0] ROW_BEQ   = 11'b0_0_0_0_0_0_1_0_0_01;
    localparam logic [BUN_W-1:0] ROW_BNE   = 11'b1_0_0_1_0_0_0_1_0_00;
    localparam logic [BUN_W-1:0] ROW_JUMP  = 11'b1_0_0_1_0_0_0_0_1_00;

    logic [BUN_W-1:0] bundle;
    logic             enc_legal;
    logic [OP_W-1:0]  enc_op;

    logic [OP_W-1:0]  mem_q [2];
    logic [OP_W-1:0]  mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             illegal_q, illegal_d;

    logic             full;
    logic             accept;
    logic             push;
    logic             pop;

    assign bundle = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
                     mem_write, beq, bne, jump, alu_op};

    // Exact-match lookup of the bundle against the opcode table
    always_comb begin
        enc_legal = 1'b0;
        enc_op    = '0;
        case (bundle)
            ROW_LOAD:  begin enc_legal = 1'b1; enc_op = 4'b0000; end
            ROW_STORE: begin enc_legal = 1'b1; enc_op = 4'b0001; end
            ROW_BEQ:   begin enc_legal = 1'b1; enc_op = 4'b1011; end
            ROW_BNE:   begin enc_legal = 1'b1; enc_op = 4'b1100; end
            ROW_JUMP:  begin enc_legal = 1'b1; enc_op = 4'b1101; end
            ROW_RTYPE: begin
                case (r_sel)
                    2'd0:    begin enc_legal = 1'b1; enc_op = 4'b0010; end
                    2'd1:    begin enc_legal = 1'b1; enc_op = 4'b0011; end
                    2'd2:    begin enc_legal = 1'b1; enc_op = 4'b0101; end
                    default: begin enc_legal = 1'b0; enc_op = '0;      end
                endcase
            end
            default: begin enc_legal = 1'b0; enc_op = '0; end
        endcase
    end

    // Handshake qualifiers; in_ready never looks at out_ready (no pass-through)
    assign full      = (count_q == CNT_W'(DEPTH));
    assign in_ready  = ~full & ~reset;
    assign out_valid = (count_q != '0);
    assign opcode    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign illegal   = illegal_q;
    assign accept    = in_valid & in_ready;
    assign push      = accept & enc_legal;
    assign pop       = out_valid & out_ready;

    // FIFO pointer/occupancy and sticky illegal flag next-state
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        if (push) begin
            mem_d[wr_ptr_q] = enc_op;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (accept && !enc_legal) begin
            illegal_d = 1'b1;
        end
    end

    // FIFO and flag state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            mem_q[0]  <= mem_d[0];
            mem_q[1]  <= mem_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef CTRL_ENC_STATS_EN
    logic [IW-1:0] illegal_count_q, illegal_count_d;
    logic [15:0]   instr_count_q, instr_count_d;

    // Saturating illegal counter and wrapping pushed-opcode counter
    always_comb begin
        illegal_count_d = illegal_count_q;
        instr_count_d   = instr_count_q;
        if (push) begin
            instr_count_d = instr_count_q + 16'd1;
        end
        if (accept && !enc_legal && (illegal_count_q != '1)) begin
            illegal_count_d = illegal_count_q + IW'(1);
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_count_q <= '0;
            instr_count_q   <= '0;
        end else begin
            illegal_count_q <= illegal_count_d;
            instr_count_q   <= instr_count_d;
        end
    end

    assign illegal_count = illegal_count_q;
    assign instr_count   = instr_count_q;
`else
    assign illegal_count = '0;
    assign instr_count   = '0;
`endif

endmodule

// File: tb/tb_ctrl_encoder.sv
// Self-checking bench for ctrl_encoder: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_ctrl_encoder;

    localparam int unsigned IW = 8;
`ifdef CTRL_ENC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Opcode table as rows {reg_dst..jump, alu_op}; rtype opcode comes from r_sel
    localparam logic [10:0] B_LOAD  = 11'b01111000010;
    localparam logic [10:0] B_STORE = 11'b01000100010;
    localparam logic [10:0] B_RTYPE = 11'b10010000000;
    localparam logic [10:0] B_BEQ   = 11'b00000010001;
    localparam logic [10:0] B_BNE   = 11'b10010001000;
    localparam logic [10:0] B_JUMP  = 11'b10010000100;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [10:0]   bun;
    logic [1:0]    r_sel;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    opcode;
    logic          illegal;
    logic [IW-1:0] illegal_count;
    logic [15:0]   instr_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [3:0]    mq[$];
    bit            m_ill;
    int unsigned   m_ill_cnt;
    int unsigned   m_ins_cnt;

    always #5 clk = ~clk;

    ctrl_encoder #(.DEPTH(2), .IW(IW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .reg_dst       (bun[10]),
        .alu_src       (bun[9]),
        .mem_to_reg    (bun[8]),
        .reg_write     (bun[7]),
        .mem_read      (bun[6]),
        .mem_write     (bun[5]),
        .beq           (bun[4]),
        .bne           (bun[3]),
        .jump          (bun[2]),
        .alu_op        (bun[1:0]),
        .r_sel         (r_sel),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .opcode        (opcode),
        .illegal       (illegal),
        .illegal_count (illegal_count),
        .instr_count   (instr_count)
    );

    function automatic bit ref_encode(input logic [10:0] b, input logic [1:0] rs,
                                      output logic [3:0] op);
        op = 4'h0;
        if (b == B_LOAD)  begin op = 4'd0;  return 1'b1; end
        if (b == B_STORE) begin op = 4'd1;  return 1'b1; end
        if (b == B_BEQ)   begin op = 4'd11; return 1'b1; end
        if (b == B_BNE)   begin op = 4'd12; return 1'b1; end
        if (b == B_JUMP)  begin op = 4'd13; return 1'b1; end
        if (b == B_RTYPE && rs != 2'd3) begin
            op = (rs == 2'd0) ? 4'd2 : (rs == 2'd1) ? 4'd3 : 4'd5;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [IW-1:0] exp_ill_cnt();
        return STATS ? IW'(m_ill_cnt) : '0;
    endfunction

    function automatic logic [15:0] exp_ins_cnt();
        return STATS ? 16'(m_ins_cnt) : 16'd0;
    endfunction

    // Advance one clock, updating the model from the inputs present at the edge
    task automatic cycle();
        bit acc, pp, leg;
        logic [3:0] op;
        acc = in_valid && !reset && (mq.size() < 2);
        pp  = !reset && out_ready && (mq.size() > 0);
        leg = ref_encode(bun, r_sel, op);
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            m_ill = 0; m_ill_cnt = 0; m_ins_cnt = 0;
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) begin
                if (leg) begin
                    mq.push_back(op);
                    m_ins_cnt = (m_ins_cnt + 1) % 65536;
                end else begin
                    m_ill = 1;
                    if (m_ill_cnt < (1 << IW) - 1) m_ill_cnt++;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 0; out_ready = 0; bun = '0; r_sel = '0;
        cycle(); cycle();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (opcode !== 4'h0) begin n_err++; $display("FAIL reset_opcode got=%h exp=0", opcode); end
        n_vec++; if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        n_vec++; if (illegal_count !== '0 || instr_count !== '0) begin
            n_err++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", illegal_count, instr_count); end
        reset = 0; #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_load();
        bun = B_LOAD; in_valid = 1; out_ready = 1;
        cycle();
        in_valid = 0;
        n_vec++; if (out_valid !== 1'b1 || opcode !== 4'b0000) begin
            n_err++; $display("FAIL load_opcode got=%b/%b exp=1/0000", out_valid, opcode); end
        n_vec++; if (instr_count !== (STATS ? 16'd1 : 16'd0)) begin
            n_err++; $display("FAIL load_instr_count got=%0d exp=%0d", instr_count, STATS ? 1 : 0); end
        cycle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL load_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_rtype_b2b();
        logic [3:0] exp_r [3];
        exp_r[0] = 4'b0010; exp_r[1] = 4'b0011; exp_r[2] = 4'b0101;
        bun = B_RTYPE; in_valid = 1; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            r_sel = 2'(i);
            cycle();
            n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || opcode !== exp_r[i]) begin
                n_err++; $display("FAIL rtype_b2b[%0d] got rdy=%b vld=%b op=%b exp 1/1/%b",
                                  i, in_ready, out_valid, opcode, exp_r[i]); end
        end
        in_valid = 0; r_sel = 0;
        cycle();
    endtask

    task automatic test_back_to_back_full();
        out_ready = 0; in_valid = 1;
        bun = B_BEQ;  cycle();
        bun = B_JUMP; cycle();
        in_valid = 0;
        n_vec++; if (in_ready !== 1'b0 || opcode !== 4'b1011) begin
            n_err++; $display("FAIL full_state got rdy=%b op=%b exp 0/1011", in_ready, opcode); end
        out_ready = 1;
        cycle();
        n_vec++; if (out_valid !== 1'b1 || opcode !== 4'b1101 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL full_second got vld=%b op=%b rdy=%b exp 1/1101/1", out_valid, opcode, in_ready); end
        cycle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        reset = 1; cycle(); reset = 0;
        out_ready = 1; in_valid = 1;
        bun = 11'b01111100010; cycle();
        bun = B_RTYPE; r_sel = 2'd3; cycle();
        in_valid = 0; r_sel = 0;
        n_vec++; if (out_valid !== 1'b0 || illegal !== 1'b1) begin
            n_err++; $display("FAIL illegal_flag got vld=%b ill=%b exp 0/1", out_valid, illegal); end
        n_vec++; if (illegal_count !== (STATS ? IW'(2) : '0) || illegal_count !== exp_ill_cnt()) begin
            n_err++; $display("FAIL illegal_count got=%0d exp=%0d", illegal_count, exp_ill_cnt()); end
    endtask

    task automatic test_saturation();
        in_valid = 1; out_ready = 1; bun = B_STORE | 11'b00001000000;
        for (int i = 0; i < 300; i++) cycle();
        in_valid = 0;
        n_vec++; if (illegal_count !== (STATS ? {IW{1'b1}} : '0) || illegal !== 1'b1) begin
            n_err++; $display("FAIL saturate got=%0d ill=%b exp=%0d/1", illegal_count, illegal, STATS ? 255 : 0); end
    endtask

    task automatic test_reset_midtraffic();
        out_ready = 0; in_valid = 1; bun = B_LOAD;
        cycle(); cycle();
        in_valid = 0;
        n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_full got rdy=%b vld=%b exp 0/1", in_ready, out_valid); end
        reset = 1; cycle();
        n_vec++; if (out_valid !== 1'b0 || illegal !== 1'b0 || illegal_count !== '0
                     || instr_count !== '0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_reset got vld=%b ill=%b ic=%0d nc=%0d rdy=%b exp 0/0/0/0/0",
                              out_valid, illegal, illegal_count, instr_count, in_ready); end
        reset = 0; #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_release got=%b exp=1", in_ready); end
    endtask

    task automatic test_random();
        logic [10:0] rows [6];
        rows[0] = B_LOAD; rows[1] = B_STORE; rows[2] = B_RTYPE;
        rows[3] = B_BEQ;  rows[4] = B_BNE;   rows[5] = B_JUMP;
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            bun       = ($urandom_range(0, 4) != 0) ? rows[$urandom_range(0, 5)] : 11'($urandom);
            r_sel     = 2'($urandom);
            cycle();
            reset = 0; #1;
            n_vec++; if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
                n_err++; $display("FAIL rnd_hs[%0d] got vld=%b rdy=%b exp %b/%b",
                                  i, out_valid, in_ready, mq.size() > 0, mq.size() < 2); end
            n_vec++; if (opcode !== ((mq.size() > 0) ? mq[0] : 4'h0)) begin
                n_err++; $display("FAIL rnd_op[%0d] got=%b exp=%b", i, opcode, (mq.size() > 0) ? mq[0] : 4'h0); end
            n_vec++; if (illegal !== m_ill || illegal_count !== exp_ill_cnt() || instr_count !== exp_ins_cnt()) begin
                n_err++; $display("FAIL rnd_stats[%0d] got ill=%b ic=%0d nc=%0d exp %b/%0d/%0d",
                                  i, illegal, illegal_count, instr_count, m_ill, exp_ill_cnt(), exp_ins_cnt()); end
        end
    endtask

    initial begin
        m_ill = 0; m_ill_cnt = 0; m_ins_cnt = 0;
        test_reset();
        test_load();
        test_rtype_b2b();
        test_back_to_back_full();
        test_illegal();
        test_saturation();
        test_reset_midtraffic();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
